// File: rtl/irq_req_pkg.sv
// rtl/irq_req_pkg.sv - shared types and constants for the interrupt requester
package irq_req_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [31:0] CAUSE_BASE = 32'h1000_0010;
    localparam int          N_SRC_MAX  = 16;
    localparam int          ID_W       = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-wins priority encoder
import irq_req_pkg::*;

module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0]    vec,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        valid = |vec;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_requester.sv
// rtl/irq_requester.sv - edge-triggered interrupt source; optional IRQ_REQ_OVF_EN overflow flags
import irq_req_pkg::*;

module irq_requester #(
    parameter int N_SRC = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] event_i,
    input  logic [N_SRC-1:0] mask_i,
    input  logic             irq_i,
    input  logic             irq_ret_i,
    input  logic             ovf_clr_i,
    output logic             irq_req_o,
    output logic [ID_W-1:0]  irq_id_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_SRC-1:0] pending_o,
    output logic [N_SRC-1:0] ovf_o
);

    state_t           state;
    logic [N_SRC-1:0] event_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  svc_id;
    logic             win_valid;
    logic [ID_W-1:0]  win_id;

    assign rise     = event_i & ~event_q;
    assign eligible = pending & mask_i;

    irq_prio_enc #(.N(N_SRC)) u_prio (
        .vec   (eligible),
        .valid (win_valid),
        .idx   (win_id)
    );

    always_comb begin
        clr = '0;
        if (state == SERVICE && irq_ret_i) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (ID_W'(i) == svc_id) begin
                    clr[i] = 1'b1;
                end
            end
        end
    end

    // A rise on the bit being cleared re-sets it because rise is ORed after the clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            event_q <= '0;
            pending <= '0;
            id_q    <= '0;
            svc_id  <= '0;
        end else begin
            event_q <= event_i;
            pending <= (pending & ~clr) | rise;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state <= REQ;
                        id_q  <= win_id;
                    end
                end
                REQ: begin
                    if (irq_i) begin
                        state  <= SERVICE;
                        svc_id <= id_q;
                    end else if (!win_valid) begin
                        state <= IDLE;
                    end else begin
                        id_q <= win_id;
                    end
                end
                SERVICE: begin
                    if (irq_ret_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign irq_req_o   = (state == REQ);
    assign irq_id_o    = id_q;
    assign irq_cause_o = CAUSE_BASE + 32'(id_q);
    assign pending_o   = pending;

`ifdef IRQ_REQ_OVF_EN
    logic [N_SRC-1:0] ovf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf_clr_i ? '0 : ovf) | (rise & pending & ~clr);
        end
    end

    assign ovf_o = ovf;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr_i;
    assign ovf_o          = '0;
`endif

endmodule

// File: tb/tb_irq_requester.sv
// tb/tb_irq_requester.sv - randomized and directed self-checking bench for irq_requester
module tb_irq_requester;

    localparam int N = 8;
    localparam logic [31:0] BASE = 32'h1000_0010;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] event_i;
    logic [N-1:0] mask_i;
    logic         irq_i;
    logic         irq_ret_i;
    logic         ovf_clr_i;
    logic         irq_req_o;
    logic [3:0]   irq_id_o;
    logic [31:0]  irq_cause_o;
    logic [N-1:0] pending_o;
    logic [N-1:0] ovf_o;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovf;
    bit           ovf_en;

    irq_requester #(.N_SRC(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .event_i     (event_i),
        .mask_i      (mask_i),
        .irq_i       (irq_i),
        .irq_ret_i   (irq_ret_i),
        .ovf_clr_i   (ovf_clr_i),
        .irq_req_o   (irq_req_o),
        .irq_id_o    (irq_id_o),
        .irq_cause_o (irq_cause_o),
        .pending_o   (pending_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Model of one event pulse: each rising line becomes pending, a repeat counts as lost.
    task automatic pulse(input logic [N-1:0] v);
        if (ovf_en) m_ovf = m_ovf | (v & m_pend);
        m_pend  = m_pend | v;
        event_i = v;
        tick();
        event_i = '0;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, 32'(irq_req_o), 32'd0);
        check({tag, "_id"}, 32'(irq_id_o), 32'd0);
        check({tag, "_cause"}, irq_cause_o, BASE);
        check({tag, "_pend"}, 32'(pending_o), 32'd0);
        check({tag, "_ovf"}, 32'(ovf_o), 32'd0);
    endtask

    task automatic serve(input int id);
        check("serve_req", 32'(irq_req_o), 32'd1);
        check("serve_id", 32'(irq_id_o), 32'(id));
        check("serve_cause", irq_cause_o, BASE + 32'(id));
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        check("accept_req_low", 32'(irq_req_o), 32'd0);
        check("accept_id_frozen", 32'(irq_id_o), 32'(id));
        irq_ret_i = 1'b1;
        tick();
        irq_ret_i = 1'b0;
        m_pend[id] = 1'b0;
        check("ret_pend", 32'(pending_o), 32'(m_pend));
        tick();
    endtask

    initial begin
`ifdef IRQ_REQ_OVF_EN
        ovf_en = 1'b1;
`else
        ovf_en = 1'b0;
`endif
        m_pend = '0;
        m_ovf = '0;
        rst = 1'b1;
        event_i = '0;
        mask_i = '1;
        irq_i = 1'b0;
        irq_ret_i = 1'b0;
        ovf_clr_i = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Strays outside their states do nothing.
        irq_i = 1'b1;
        irq_ret_i = 1'b1;
        tick();
        irq_i = 1'b0;
        irq_ret_i = 1'b0;
        check("stray_req", 32'(irq_req_o), 32'd0);

        // Single event on source 3: request two edges after the rise.
        event_i = 8'h08;
        m_pend = 8'h08;
        tick();
        event_i = '0;
        check("single_pend", 32'(pending_o), 32'h08);
        check("single_req_early", 32'(irq_req_o), 32'd0);
        tick();
        serve(3);

        // Priority: 5 and 2 together; 2 first, 5 one cycle after IDLE.
        pulse(8'h24);
        serve(2);
        serve(5);

        // Masking.
        mask_i = 8'hEF;
        pulse(8'h10);
        tick();
        check("mask_noreq", 32'(irq_req_o), 32'd0);
        check("mask_pend", 32'(pending_o), 32'h10);
        mask_i = 8'hFF;
        tick();
        check("unmask_req", 32'(irq_req_o), 32'd1);
        check("unmask_id", 32'(irq_id_o), 32'd4);
        mask_i = 8'hEF;
        tick();
        check("withdraw_req", 32'(irq_req_o), 32'd0);
        check("withdraw_pend", 32'(pending_o), 32'h10);
        mask_i = 8'hFF;
        tick();
        serve(4);

        // Overflow: two rises on source 1 before service.
        pulse(8'h02);
        pulse(8'h02);
        check("ovf_set", 32'(ovf_o), 32'(m_ovf));
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        m_ovf = '0;
        check("ovf_clr", 32'(ovf_o), 32'd0);
        serve(1);

        // Randomized pulses and masks against the model.
        for (int it = 0; it < 40; it++) begin
            logic [N-1:0] v;
            logic [N-1:0] m;
            v = N'($urandom);
            m = N'($urandom);
            mask_i = m;
            pulse(v);
            check("rnd_pend", 32'(pending_o), 32'(m_pend));
            check("rnd_ovf", 32'(ovf_o), 32'(m_ovf));
            check("rnd_req", 32'(irq_req_o), 32'((m_pend & m) != 0));
            if ((m_pend & m) != 0) serve(lowest(m_pend & m));
        end

        // Drain everything left with all sources enabled.
        mask_i = 8'hFF;
        tick();
        tick();
        for (int k = 0; k < N && m_pend != 0; k++) serve(lowest(m_pend));
        check("drain_pend", 32'(pending_o), 32'd0);
        check("drain_req", 32'(irq_req_o), 32'd0);
        if (ovf_en) begin
            ovf_clr_i = 1'b1;
            tick();
            ovf_clr_i = 1'b0;
        end
        m_ovf = '0;

        // Rise on the serviced source during its return: stays pending, no overflow.
        pulse(8'h40);
        check("bnd_req", 32'(irq_req_o), 32'd1);
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        irq_ret_i = 1'b1;
        event_i = 8'h40;
        tick();
        irq_ret_i = 1'b0;
        event_i = '0;
        check("bnd_pend", 32'(pending_o), 32'h40);
        check("bnd_ovf", 32'(ovf_o), 32'd0);
        tick();
        serve(6);

        // Asynchronous reset in the middle of SERVICE.
        pulse(8'h01);
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        m_pend = '0;
        tick();
        rst = 1'b0;
        tick();
        check_reset_vals("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
